branch_global_dpath: RTL

Datapath for the global (gshare) branch predictor. Holds the global history register (GHR) and the pattern history table (PHT) of 2-bit saturating counters, and serves combinational predictions. It sits directly under the global predictor control unit: it produces the entry saturation status that control consumes, and it executes control's update_ghr / increment_entry / decrement_entry commands. It also owns a post-reset PHT initialisation sequencer.

---
 rtl/branch_global_dpath_if.sv | 29 ++
 rtl/branch_global_dpath.sv | 73 +++++++
 2 files changed

// File: rtl/branch_global_dpath_if.sv
// Bus between the gshare predictor control unit and its datapath:
// prediction lookup, training commands and saturation status.
interface branch_global_dpath_if #(
  parameter int IDX = 11
);
  logic            ready;
  logic [31:0]     predict_pc;
  logic            predict_taken;
  logic [31:0]     update_pc;
  logic            update_val;
  logic            update_ghr;
  logic            increment_entry;
  logic            decrement_entry;
  logic            entry_upper_reached;
  logic            entry_lower_reached;
  logic [IDX-1:0]  ghr;

  modport master (
    input  ready, predict_taken, entry_upper_reached, entry_lower_reached, ghr,
    output predict_pc, update_pc, update_val, update_ghr,
           increment_entry, decrement_entry
  );

  modport slave (
    output ready, predict_taken, entry_upper_reached, entry_lower_reached, ghr,
    input  predict_pc, update_pc, update_val, update_ghr,
           increment_entry, decrement_entry
  );
endinterface

// File: rtl/branch_global_dpath.sv
// gshare datapath: global history register, PHT of 2-bit saturating counters,
// combinational prediction/status reads and a post-reset PHT init sequencer.
module branch_global_dpath #(
  parameter int PHT_size = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_global_dpath_if.slave  bus
);
  localparam int IDX = $clog2(PHT_size);
  localparam logic [IDX-1:0] LAST_ENTRY = IDX'(PHT_size - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t         state_q, state_d;
  logic [IDX-1:0] init_cnt_q;
  logic [IDX-1:0] ghr_q;
  logic [1:0]     pht [PHT_size];

  logic [IDX-1:0] pidx, uidx;
  logic [1:0]     pred_ctr, upd_ctr;
  logic           is_ready;
  logic           do_inc, do_dec;

  // Both indices hash against the pre-edge history.
  assign pidx     = bus.predict_pc[IDX+1:2] ^ ghr_q;
  assign uidx     = bus.update_pc[IDX+1:2] ^ ghr_q;
  assign pred_ctr = pht[pidx];
  assign upd_ctr  = pht[uidx];
  assign is_ready = (state_q == S_READY);

  // Saturation is re-checked here; an inc+dec collision writes nothing.
  assign do_inc = is_ready && bus.increment_entry && !bus.decrement_entry && (upd_ctr != 2'b11);
  assign do_dec = is_ready && bus.decrement_entry && !bus.increment_entry && (upd_ctr != 2'b00);

  always_comb begin
    // NOTE: defaults first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (state_q == S_INIT && init_cnt_q == LAST_ENTRY) state_d = S_READY;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) init_cnt_q <= init_cnt_q + 1'b1;
      if (is_ready && bus.update_ghr) ghr_q <= {ghr_q[IDX-2:0], bus.update_val};
    end
  end

  // NOTE: the PHT has no reset; the init sequencer rewrites every entry instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_INIT)  pht[init_cnt_q] <= 2'b01;
      else if (do_inc)        pht[uidx]       <= upd_ctr + 2'b01;
      else if (do_dec)        pht[uidx]       <= upd_ctr - 2'b01;
    end
  end

  assign bus.ready               = is_ready;
  assign bus.predict_taken       = is_ready && pred_ctr[1];
  assign bus.entry_upper_reached = is_ready && (upd_ctr == 2'b11);
  assign bus.entry_lower_reached = is_ready && (upd_ctr == 2'b00);
  assign bus.ghr                 = ghr_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.predict_pc[31:IDX+2], bus.predict_pc[1:0],
                            bus.update_pc[31:IDX+2], bus.update_pc[1:0]};
endmodule
